// File: rtl/seq_scan_pkg.sv
// Shared types and constants for the serial scan controller and its detector.
package seq_scan_pkg;

  localparam int PAT_W    = 4;
  localparam int FILL_MAX = 4;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WAIT  = 3'd1,
    ST_SHIFT = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

endpackage

// File: rtl/seq_scan_det.sv
// Moore 4-bit serial pattern detector with registered match pulse.
// Build option: SEQ_SCAN_OVERLAP_EN selects overlapping detection; when it is
// undefined a match restarts the window so the next bit opens a fresh one.
module seq_scan_det
  import seq_scan_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             adv,
  input  logic             bit_in,
  input  logic [PAT_W-1:0] pattern,
  output logic             match
);

  logic [PAT_W-1:0] r_hist;
  logic [2:0]       r_fill;
  logic             r_match;

  logic [PAT_W-1:0] w_hist_nxt;
  logic [2:0]       w_fill_nxt;
  logic             w_hit;

  // Next history/fill for an advance, and whether that advance completes a match.
  always_comb begin
    w_hist_nxt = {r_hist[PAT_W-2:0], bit_in};
    w_fill_nxt = (r_fill == 3'(FILL_MAX)) ? r_fill : r_fill + 3'd1;
    w_hit      = (w_fill_nxt == 3'(FILL_MAX)) && (w_hist_nxt == pattern);
  end

  // History, fill level and match register; clr wipes everything at job start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hist  <= '0;
      r_fill  <= '0;
      r_match <= 1'b0;
    end else if (clr) begin
      r_hist  <= '0;
      r_fill  <= '0;
      r_match <= 1'b0;
    end else begin
      r_match <= adv && w_hit;
      if (adv) begin
        r_hist <= w_hist_nxt;
`ifdef SEQ_SCAN_OVERLAP_EN
        r_fill <= w_fill_nxt;
`else
        // Dropping fill to 0 on a hit makes the following advance land at 1,
        // i.e. the next bit begins a brand-new window, however far away it is.
        r_fill <= w_hit ? 3'd0 : w_fill_nxt;
`endif
      end
    end
  end

  assign match = r_match;

endmodule

// File: rtl/seq_scan_ctrl.sv
// Job controller: pulls words over valid/ready, serializes them MSB-first into
// the pattern detector and reports the per-job match total with a done pulse.
// Build option: SEQ_SCAN_OVERLAP_EN (resolved inside seq_scan_det).
//
// Handshake: a word transfers on a rising edge where in_valid && in_ready.
// in_ready is high exactly while the FSM sits in WAIT and does not depend on
// in_valid; in_valid/in_data seen in any other state are ignored and the
// source must keep holding its word until it is accepted.
module seq_scan_ctrl
  import seq_scan_pkg::*;
#(
  parameter int WORD_W   = 8,
  parameter int NWORDS_W = 4,
  parameter int CNT_W    = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [PAT_W-1:0]    cfg_pattern,
  input  logic [NWORDS_W-1:0] cfg_nwords,
  input  logic                start,
  input  logic                in_valid,
  input  logic [WORD_W-1:0]   in_data,
  output logic                in_ready,
  output logic                busy,
  output logic                bit_out,
  output logic                match,
  output logic                done,
  output logic [CNT_W-1:0]    match_cnt,
  output logic [2:0]          dbg_state
);

  localparam int BIT_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;

  state_t              r_state;
  logic [PAT_W-1:0]    r_pattern;
  logic [NWORDS_W-1:0] r_words;   // words still to be accepted in this job
  logic [WORD_W-1:0]   r_sh;
  logic [BIT_W-1:0]    r_bit;
  logic [CNT_W-1:0]    r_cnt;

  logic w_clr;
  logic w_adv;
  logic w_match;
  logic w_last_bit;

  assign w_clr      = (r_state == ST_IDLE) && start;
  assign w_adv      = (r_state == ST_SHIFT);
  assign w_last_bit = (r_bit == BIT_W'(WORD_W - 1));

  // Job sequencing: config capture, word load, serialization and completion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_pattern <= '0;
      r_words   <= '0;
      r_sh      <= '0;
      r_bit     <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_pattern <= cfg_pattern;
            r_words   <= cfg_nwords;
            r_state   <= (cfg_nwords == '0) ? ST_DONE : ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (in_valid) begin
            r_sh    <= in_data;
            r_bit   <= '0;
            r_words <= r_words - 1'b1;
            r_state <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          r_sh  <= r_sh << 1;
          r_bit <= r_bit + 1'b1;
          if (w_last_bit) begin
            r_state <= (r_words == '0) ? ST_DRAIN : ST_WAIT;
          end
        end
        // One extra cycle so the last bit's match pulse reaches the counter.
        ST_DRAIN: r_state <= ST_DONE;
        ST_DONE:  r_state <= ST_IDLE;
        default:  r_state <= ST_IDLE;
      endcase
    end
  end

  // Saturating match counter, cleared by an accepted start and held otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (w_clr) begin
      r_cnt <= '0;
    end else if (w_match && (r_cnt != '1)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  seq_scan_det u_det (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (w_clr),
    .adv     (w_adv),
    .bit_in  (r_sh[WORD_W-1]),
    .pattern (r_pattern),
    .match   (w_match)
  );

  assign in_ready  = (r_state == ST_WAIT);
  assign busy      = (r_state != ST_IDLE);
  assign bit_out   = (r_state == ST_SHIFT) && r_sh[WORD_W-1];
  assign match     = w_match;
  assign done      = (r_state == ST_DONE);
  assign match_cnt = r_cnt;
  assign dbg_state = r_state;

endmodule

// File: doc/seq_scan_ctrl.md
# seq_scan_ctrl

Job controller for the team's serial pattern detectors. It accepts a programmed 4-bit pattern and word count, pulls parallel words over a valid/ready handshake, and serializes each word MSB-first into an embedded Moore pattern detector. It counts detector matches across the whole job and reports the total with a `done` pulse. It sits between a word-producing source (FIFO/DMA) and status/CSR logic.

## Interface
- `WORD_W`, 8, bits per input word (≥4)
- `NWORDS_W`, 4, width of the word-count field
- `CNT_W`, 8, width of the match counter

- `clk` in 1: single clock, all state on rising edge
- `rst_n` in 1: asynchronous, active-low reset
- `cfg_pattern` in 4: pattern; bit 3 is the earliest serial bit
- `cfg_nwords` in NWORDS_W: words per job
- `start` in 1: job request, honoured only in IDLE
- `in_valid` in 1: input word valid
- `in_data` in WORD_W: input word
- `in_ready` out 1: controller accepts a word this cycle
- `busy` out 1: job in progress (any state except IDLE)
- `bit_out` out 1: current serial bit (valid in SHIFT)
- `match` out 1: one-cycle match pulse
- `done` out 1: one-cycle job-complete pulse
- `match_cnt` out CNT_W: match total; held from DONE until the next accepted start

## Operation
- Reset value of every output is 0. The FSM resets to IDLE. Detector history, fill, counter and shift register all clear.
- FSM states: IDLE, WAIT, SHIFT, DRAIN, DONE.
- IDLE + `start`:
  - Sample `cfg_pattern` and `cfg_nwords`.
  - Clear `match_cnt` and the detector.
  - Go to DONE if `cfg_nwords`==0, else go to WAIT.
- WAIT: `in_ready`=1. On `in_valid`, load `in_data` into the shift register and go to SHIFT. Without `in_valid`, stay in WAIT.
- SHIFT: lasts exactly WORD_W cycles.
  - `bit_out` = shift register MSB.
  - The shift register moves left each cycle.
  - The detector advances once per cycle.
  - After the last bit: go to WAIT if more words remain, else go to DRAIN.
- DRAIN: one cycle, so the final bit's match pulse is counted. Then go to DONE.
- DONE: `done`=1 for one cycle, then go to IDLE.
- Detector:
  - State: `hist[3:0]` and `fill` (0..4).
  - On advance with bit b: `hist` <= {hist[2:0], b}; `fill` <= min(fill+1, 4).
  - Registered `match` <= advance && (next fill==4) && (next hist==pattern).
  - Non-overlapping (default): an advance that follows a match cycle sets `fill` to 1, so the new bit starts a fresh window.
  - Detector history persists across word boundaries within one job, so patterns may straddle words.
- `match_cnt` increments on each `match` pulse and saturates at all-ones.
- `start` outside IDLE is ignored. `in_valid` outside WAIT is ignored; the word is not consumed.
- Config inputs are ignored after sampling. Mid-job changes have no effect.
- Asserting `rst_n` low mid-job immediately returns the block to reset values. The partial job is discarded.

## Timing
- `start` at cycle t → WAIT at t+1.
- If the word is valid at t+1: bits on `bit_out` at t+2..t+1+WORD_W.
- Each match pulse appears one cycle after its completing bit.
- For one word with no stalls: DRAIN at t+2+WORD_W; `done` at t+3+WORD_W (t+11 for WORD_W=8).
- `cfg_nwords`==0: `done` at t+1, `match_cnt`=0.
- Between words: one WAIT cycle minimum, so zero-stall throughput is WORD_W bits per WORD_W+1 cycles.
- `busy` is high from t+1 through the DONE cycle.

## Configuration
- `SEQ_SCAN_OVERLAP_EN` defined: overlapping detection. `fill` stays at 4 after a match, and every qualifying window counts.
- Not defined: non-overlapping detection, as described in Operation.

## Structure
- Package `seq_scan_pkg` holds:
  - FSM state enum
  - `PAT_W`=4
  - `FILL_MAX`=4
- Sub-module `seq_scan_det`:
  - Contains `hist`, `fill` and the `match` register.
  - Ports: `clk`, `rst_n`, `clr`, `adv`, `bit_in`, `pattern`, `match`.
  - The overlap macro is resolved inside this sub-module.

## Test plan
- Pattern 4'b1110, nwords 1, word 8'hEE, non-overlap → `match_cnt`=2 with `done` at t+11; `match` pulses 1 cycle after bits 4 and 8.
- Pattern 4'b1111, word 8'hFF → `match_cnt`=2 without `SEQ_SCAN_OVERLAP_EN`, 5 with it.
- Pattern 4'b1110, nwords 2, words 8'h07 then 8'h00 → `match_cnt`=1 (cross-word match at the first bit of word 2).
- Backpressure: `in_valid` low for 5 cycles in WAIT → `in_ready` stays 1, no shifting, `busy`=1; job then completes with correct count and `done` delayed by 5 cycles.
- `cfg_nwords`=0 → `done` one cycle after `start`, `match_cnt`=0, `in_ready` never asserted.
- `rst_n` low in SHIFT → all outputs 0 immediately; the next `start` with 8'hEE, pattern 4'b1110 yields `match_cnt`=2; a `start` pulsed while `busy` has no effect.
